// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus responder: DDRAM geometry, error codes,
// init-state encoding, command classification and DDRAM address stepping.
package lcd_pkg;

    localparam int         E_MIN_HIGH_DEF = 4;
    localparam logic [7:0] BLANK          = 8'h20;

    localparam logic [6:0] LINE0_BASE  = 7'h00;
    localparam logic [6:0] LINE1_BASE  = 7'h40;
    localparam logic [6:0] LINE0_LIMIT = 7'h27;
    localparam logic [6:0] LINE1_LIMIT = 7'h67;

    localparam logic [3:0] FUNC_SET_HI = 4'h3;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_GLITCH  = 3'd1;
    localparam logic [2:0] ERR_BUSY    = 3'd2;
    localparam logic [2:0] ERR_PREINIT = 3'd3;
    localparam logic [2:0] ERR_READ    = 3'd4;
    localparam logic [2:0] ERR_UNSUP   = 3'd5;

    typedef enum logic [1:0] {ST_UNINIT, ST_INIT1, ST_INIT2, ST_READY} init_state_t;

    typedef enum logic [3:0] {
        CMD_NONE, CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISPLAY,
        CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM
    } cmd_t;

    // HD44780 opcodes are identified by their most significant set bit.
    function automatic cmd_t decode_cmd(input logic [7:0] d);
        if (d[7]) return CMD_DDRAM;
        if (d[6]) return CMD_CGRAM;
        if (d[5]) return CMD_FUNC;
        if (d[4]) return CMD_SHIFT;
        if (d[3]) return CMD_DISPLAY;
        if (d[2]) return CMD_ENTRY;
        if (d[1]) return CMD_HOME;
        if (d[0]) return CMD_CLEAR;
        return CMD_NONE;
    endfunction

    // Addresses in the holes between the two 40-byte lines snap back onto a line edge.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic off_line;
        off_line = (a > LINE0_LIMIT && a < LINE1_BASE) || (a > LINE1_LIMIT);
        if (off_line) return inc ? LINE1_BASE : LINE0_LIMIT;
        if (inc) begin
            if (a == LINE0_LIMIT) return LINE1_BASE;
            if (a == LINE1_LIMIT) return LINE0_BASE;
            return a + 7'd1;
        end
        if (a == LINE0_BASE) return LINE1_LIMIT;
        if (a == LINE1_BASE) return LINE0_LIMIT;
        return a - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_strobe_detect.sv
// Registers the raw LCD bus and turns each E pulse into a strobe or glitch
// pulse, qualified by a saturating E-high length counter.
module lcd_strobe_detect
    import lcd_pkg::*;
#(
    parameter int E_MIN_HIGH = E_MIN_HIGH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    output logic       strobe,
    output logic       glitch,
    output logic       st_rs,
    output logic       st_rw,
    output logic [7:0] st_data
);

    logic       e_q, e_prev, rs_q, rw_q;
    logic [7:0] data_q;
    logic [3:0] high_cnt;
    logic       fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q      <= 1'b0;
            e_prev   <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            data_q   <= 8'h00;
            high_cnt <= 4'd0;
            st_rs    <= 1'b0;
            st_rw    <= 1'b0;
            st_data  <= 8'h00;
        end else begin
            e_q    <= lcd_e;
            e_prev <= e_q;
            rs_q   <= lcd_rs;
            rw_q   <= lcd_rw;
            data_q <= lcd_data;
            // Bus fields follow E_q while high, so they hold the last E-high cycle at the fall.
            if (e_q) begin
                high_cnt <= (high_cnt == 4'hF) ? high_cnt : high_cnt + 4'd1;
                st_rs    <= rs_q;
                st_rw    <= rw_q;
                st_data  <= data_q;
            end else begin
                high_cnt <= 4'd0;
            end
        end
    end

    assign fall   = e_prev & ~e_q;
    assign strobe = fall && (high_cnt >= 4'(E_MIN_HIGH));
    assign glitch = fall && !strobe;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780 bus responder: init tracking, command/data decode, 2x16 DDRAM mirror
// with clear sweep, and a registered read port for display mirrors.
//
//  state     | meaning
//  ST_UNINIT | no function-set seen since reset
//  ST_INIT1  | one function-set seen
//  ST_INIT2  | two function-sets seen
//  ST_READY  | init complete, full command set accepted
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int E_MIN_HIGH = E_MIN_HIGH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char,
    output logic       ready,
    output logic       disp_on,
    output logic       busy,
    output logic [6:0] cursor_addr,
    output logic       acc_pulse,
    output logic       err_pulse,
    output logic [2:0] err_code
);

    logic        strobe, glitch, st_rs, st_rw;
    logic [7:0]  st_data;
    init_state_t state, state_nxt;
    logic [6:0]  cursor_nxt;
    logic        inc_mode, inc_nxt, disp_nxt;
    logic        acc, err, start_sweep, wr_en, boot;
    logic [2:0]  code;
    logic [4:0]  sweep_idx;
    cmd_t        cmd;
    logic [7:0]  mem [32];

    lcd_strobe_detect #(.E_MIN_HIGH(E_MIN_HIGH)) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data),
        .strobe   (strobe),
        .glitch   (glitch),
        .st_rs    (st_rs),
        .st_rw    (st_rw),
        .st_data  (st_data)
    );

    always_comb begin
        state_nxt   = state;
        cursor_nxt  = cursor_addr;
        inc_nxt     = inc_mode;
        disp_nxt    = disp_on;
        acc         = 1'b0;
        err         = 1'b0;
        code        = ERR_NONE;
        start_sweep = 1'b0;
        wr_en       = 1'b0;
        cmd         = decode_cmd(st_data);
        if (glitch) begin
            err  = 1'b1;
            code = ERR_GLITCH;
        end else if (strobe) begin
            if (busy) begin
                err  = 1'b1;
                code = ERR_BUSY;
            end else if (state != ST_READY) begin
                if (!st_rs && !st_rw && st_data[7:4] == FUNC_SET_HI) begin
                    acc = 1'b1;
                    unique case (state)
                        ST_UNINIT: state_nxt = ST_INIT1;
                        ST_INIT1:  state_nxt = ST_INIT2;
                        default:   state_nxt = ST_READY;
                    endcase
                end else begin
                    err  = 1'b1;
                    code = ERR_PREINIT;
                end
            end else if (st_rw) begin
                err  = 1'b1;
                code = ERR_READ;
            end else if (st_rs) begin
                // Writes outside the two visible 16-column windows are dropped but still step.
                acc        = 1'b1;
                wr_en      = (cursor_addr[5:4] == 2'b00);
                cursor_nxt = step_addr(cursor_addr, inc_mode);
            end else begin
                acc = 1'b1;
                case (cmd)
                    CMD_CLEAR: begin
                        start_sweep = 1'b1;
                        cursor_nxt  = LINE0_BASE;
                        inc_nxt     = 1'b1;
                    end
                    CMD_HOME:    cursor_nxt = LINE0_BASE;
                    CMD_ENTRY:   if (st_data[0]) acc = 1'b0; else inc_nxt = st_data[1];
                    CMD_DISPLAY: disp_nxt = st_data[2];
                    CMD_SHIFT: begin
                        if (st_data[3]) acc = 1'b0;
                        else cursor_nxt = step_addr(cursor_addr, st_data[2]);
                    end
                    CMD_FUNC:    acc = 1'b1;
                    CMD_DDRAM:   cursor_nxt = st_data[6:0];
                    default:     acc = 1'b0;
                endcase
                if (!acc) begin
                    err  = 1'b1;
                    code = ERR_UNSUP;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_UNINIT;
            boot        <= 1'b1;
            busy        <= 1'b0;
            sweep_idx   <= 5'd0;
            cursor_addr <= LINE0_BASE;
            inc_mode    <= 1'b1;
            disp_on     <= 1'b0;
            acc_pulse   <= 1'b0;
            err_pulse   <= 1'b0;
            err_code    <= ERR_NONE;
            rd_char     <= BLANK;
        end else begin
            state       <= state_nxt;
            boot        <= 1'b0;
            cursor_addr <= cursor_nxt;
            inc_mode    <= inc_nxt;
            disp_on     <= disp_nxt;
            acc_pulse   <= acc;
            err_pulse   <= err;
            if (err) err_code <= code;
            if (boot || start_sweep) begin
                busy      <= 1'b1;
                sweep_idx <= 5'd0;
            end else if (busy) begin
                if (sweep_idx == 5'd31) busy <= 1'b0;
                sweep_idx <= sweep_idx + 5'd1;
            end
            rd_char <= (busy || !disp_on) ? BLANK : mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (busy) mem[sweep_idx] <= BLANK;
        else if (wr_en) mem[{cursor_addr[6], cursor_addr[3:0]}] <= st_data;
    end

    assign ready = (state == ST_READY);

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: init, writes, address wrap,
// error causes, display blanking, busy sweep and reset in mid-strobe.
module tb_lcd_hd44780_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_idx = 5'd0;
    logic [7:0] rd_char;
    logic       ready, disp_on, busy, acc_pulse, err_pulse;
    logic [6:0] cursor_addr;
    logic [2:0] err_code;

    lcd_hd44780_responder dut (
        .clk         (clk),
        .rst         (rst),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_data    (lcd_data),
        .rd_idx      (rd_idx),
        .rd_char     (rd_char),
        .ready       (ready),
        .disp_on     (disp_on),
        .busy        (busy),
        .cursor_addr (cursor_addr),
        .acc_pulse   (acc_pulse),
        .err_pulse   (err_pulse),
        .err_code    (err_code)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] d;
        int         hi;
        logic [2:0] code;
        logic [6:0] cur;
        logic       we;
        logic [4:0] idx;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_mem [32];
    int         n_cmp = 0, n_bad = 0;
    int         acc_seen = 0, err_seen = 0, busy_cycles = 0;

    always @(negedge clk) begin
        if (acc_pulse) acc_seen++;
        if (err_pulse) err_seen++;
        if (busy) busy_cycles++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic rs, input logic rw, input logic [7:0] d, input int hi);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (hi) @(negedge clk);
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic check_char(input int idx, input logic [7:0] exp);
        @(negedge clk);
        rd_idx = idx[4:0];
        @(negedge clk);
        check($sformatf("rd_char[%0d]", idx), 32'(rd_char), 32'(exp));
    endtask

    task automatic add(input logic rs, input logic rw, input logic [7:0] d, input int hi,
                       input logic [2:0] code, input logic [6:0] cur,
                       input logic we, input logic [4:0] idx);
        vec_t v;
        v.rs = rs; v.rw = rw; v.d = d; v.hi = hi;
        v.code = code; v.cur = cur; v.we = we; v.idx = idx;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string msg;
        int a0, e0;

        msg = "ODO: 12345 km";
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;

        // rs rw data hi | code cursor | we idx   (cursor starts at 0x41)
        add(0, 0, 8'hA7, 10, 0, 7'h27, 0, 0);
        add(1, 0, 8'h5A, 10, 0, 7'h40, 0, 0);
        add(0, 0, 8'h04, 10, 0, 7'h40, 0, 0);
        add(0, 0, 8'h80, 10, 0, 7'h00, 0, 0);
        add(1, 0, 8'h51, 10, 0, 7'h67, 1, 0);
        add(0, 0, 8'h06, 10, 0, 7'h67, 0, 0);
        add(1, 0, 8'h47,  2, 1, 7'h67, 0, 0);
        add(1, 1, 8'h00, 10, 4, 7'h67, 0, 0);
        add(0, 0, 8'h40, 10, 5, 7'h67, 0, 0);
        add(0, 0, 8'h05, 10, 5, 7'h67, 0, 0);
        add(0, 0, 8'h18, 10, 5, 7'h67, 0, 0);
        add(0, 0, 8'h00, 10, 5, 7'h67, 0, 0);
        add(0, 0, 8'h14, 10, 0, 7'h00, 0, 0);
        add(0, 0, 8'h10, 10, 0, 7'h67, 0, 0);
        add(1, 0, 8'h41, 10, 0, 7'h00, 0, 0);
        add(0, 0, 8'h8F, 10, 0, 7'h0F, 0, 0);
        add(1, 0, 8'h45, 10, 0, 7'h10, 1, 15);
        add(1, 0, 8'h57, 10, 0, 7'h11, 0, 0);
        add(0, 0, 8'hCF, 10, 0, 7'h4F, 0, 0);
        add(1, 0, 8'h4C, 10, 0, 7'h50, 1, 31);
        add(0, 0, 8'hE8, 10, 0, 7'h68, 0, 0);
        add(1, 0, 8'h4B, 10, 0, 7'h40, 0, 0);
        add(0, 0, 8'h03, 10, 0, 7'h00, 0, 0);
        add(1, 0, 8'h4D,  4, 0, 7'h01, 1, 0);
        add(1, 0, 8'h4E,  3, 1, 7'h01, 0, 0);
        add(0, 0, 8'h02, 10, 0, 7'h00, 0, 0);

        // reset state
        repeat (3) @(negedge clk);
        check("rst rd_char", 32'(rd_char), 32'h20);
        check("rst cursor", 32'(cursor_addr), 32'h0);
        check("rst ready", 32'(ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst disp_on", 32'(disp_on), 32'd0);
        check("rst err_code", 32'(err_code), 32'd0);
        check("rst pulses", 32'({acc_pulse, err_pulse}), 32'd0);

        rst = 1'b0;
        busy_cycles = 0;
        @(negedge clk);
        check("boot busy", 32'(busy), 32'd1);
        wait_idle("boot sweep ends");
        check("boot busy length", 32'(busy_cycles), 32'd32);

        // strobes before init
        send(1, 0, 8'h58, 10);
        check("preinit data code", 32'(err_code), 32'd3);
        send(0, 0, 8'h08, 10);
        check("preinit cmd code", 32'(err_code), 32'd3);
        check("preinit errs", 32'(err_seen), 32'd2);
        check("preinit accs", 32'(acc_seen), 32'd0);
        check("preinit ready", 32'(ready), 32'd0);

        // init sequence
        acc_seen = 0; err_seen = 0;
        send(0, 0, 8'h30, 10);
        send(0, 0, 8'h30, 10);
        check("ready after two 0x30", 32'(ready), 32'd0);
        send(0, 0, 8'h30, 10);
        check("ready after three 0x30", 32'(ready), 32'd1);
        send(0, 0, 8'h38, 10);
        send(0, 0, 8'h08, 10);
        busy_cycles = 0;
        send(0, 0, 8'h01, 10);
        wait_idle("clear sweep ends");
        check("clear busy length", 32'(busy_cycles), 32'd32);
        send(0, 0, 8'h06, 10);
        send(0, 0, 8'h0C, 10);
        check("init ready", 32'(ready), 32'd1);
        check("init disp_on", 32'(disp_on), 32'd1);
        check("init errs", 32'(err_seen), 32'd0);
        check("init accs", 32'(acc_seen), 32'd8);

        // text write
        send(0, 0, 8'h80, 10);
        for (int i = 0; i < msg.len(); i++) begin
            send(1, 0, msg[i], 10);
            exp_mem[i] = msg[i];
        end
        check("cursor after text", 32'(cursor_addr), 32'h0D);
        for (int i = 0; i < msg.len(); i++) check_char(i, exp_mem[i]);
        send(0, 0, 8'hC0, 10);
        send(1, 0, 8'h46, 10);
        exp_mem[16] = 8'h46;
        check_char(16, 8'h46);
        check("cursor after F", 32'(cursor_addr), 32'h41);

        // table: wrap, entry mode, error causes, E-length boundary
        for (int i = 0; i < vecs.size(); i++) begin
            a0 = acc_seen; e0 = err_seen;
            send(vecs[i].rs, vecs[i].rw, vecs[i].d, vecs[i].hi);
            if (vecs[i].code == 3'd0) begin
                check($sformatf("vec%0d acc", i), 32'(acc_seen - a0), 32'd1);
                check($sformatf("vec%0d err", i), 32'(err_seen - e0), 32'd0);
            end else begin
                check($sformatf("vec%0d acc", i), 32'(acc_seen - a0), 32'd0);
                check($sformatf("vec%0d err", i), 32'(err_seen - e0), 32'd1);
                check($sformatf("vec%0d code", i), 32'(err_code), 32'(vecs[i].code));
            end
            check($sformatf("vec%0d cursor", i), 32'(cursor_addr), 32'(vecs[i].cur));
            if (vecs[i].we) exp_mem[vecs[i].idx] = vecs[i].d;
        end

        // display off blanks the read port, on restores it
        send(0, 0, 8'h08, 10);
        for (int i = 0; i < 32; i++) check_char(i, 8'h20);
        send(0, 0, 8'h0C, 10);
        for (int i = 0; i < 32; i++) check_char(i, exp_mem[i]);

        // data during clear sweep
        send(0, 0, 8'h01, 10);
        check("sweep busy", 32'(busy), 32'd1);
        e0 = err_seen;
        send(1, 0, 8'h59, 4);
        check("busy err count", 32'(err_seen - e0), 32'd1);
        check("busy code", 32'(err_code), 32'd2);
        wait_idle("second clear ends");
        check("busy cursor", 32'(cursor_addr), 32'h00);
        for (int i = 0; i < 32; i++) check_char(i, 8'h20);

        // reset while E is high
        send(0, 0, 8'h80, 10);
        send(1, 0, 8'h58, 10);
        check_char(0, 8'h58);
        @(negedge clk);
        lcd_rs = 1'b1; lcd_data = 8'h59; lcd_e = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        lcd_e = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst ready", 32'(ready), 32'd0);
        check("midrst cursor", 32'(cursor_addr), 32'h00);
        check("midrst err_code", 32'(err_code), 32'd0);
        a0 = acc_seen; e0 = err_seen;
        rst = 1'b0;
        @(negedge clk);
        wait_idle("midrst sweep ends");
        check("midrst no pulses", 32'((acc_seen - a0) + (err_seen - e0)), 32'd0);
        check("midrst ready after", 32'(ready), 32'd0);
        send(0, 0, 8'h30, 10);
        send(0, 0, 8'h30, 10);
        send(0, 0, 8'h30, 10);
        send(0, 0, 8'h0C, 10);
        check("reinit ready", 32'(ready), 32'd1);
        for (int i = 0; i < 32; i++) check_char(i, 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
